// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed little-endian byte stream into sequential
// instruction-memory writes. Define IMEM_LOADER_CHECKSUM_EN for an XOR trailer check.
module imem_loader #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        cpu_rst,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WR,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_fin;
    logic [15:0] r_len;
    logic [1:0]  r_idx;
    logic [31:0] r_wdata;
    logic [31:0] r_addr;
    logic [15:0] r_cnt;
    logic [15:0] w_len;
    logic        w_take;
    logic        w_rdy_chk;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  r_xor;
    assign w_fin     = S_CHK;
    assign w_rdy_chk = (r_state == S_CHK);
`else
    assign w_fin     = S_DONE;
    assign w_rdy_chk = 1'b0;
`endif

    // Full length as it will be once the high byte in LEN1 is taken
    assign w_len  = {in_data, r_len[7:0]};
    assign w_take = in_valid && in_ready;

    assign in_ready = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                      (r_state == S_DATA) || w_rdy_chk;
    assign mem_we        = (r_state == S_WR);
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign busy          = in_ready || mem_we;
    assign done          = (r_state == S_DONE);
    assign error         = (r_state == S_ERR);
    assign cpu_rst       = done;
    assign words_written = r_cnt;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) w_next = S_LEN0;
            end
            S_LEN0: begin
                if (in_valid) w_next = S_LEN1;
            end
            S_LEN1: begin
                if (in_valid) begin
                    if ({16'd0, w_len} > 32'(DEPTH)) w_next = S_ERR;
                    else if (w_len == 16'd0)         w_next = w_fin;
                    else                             w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (in_valid && (r_idx == 2'd3)) w_next = S_WR;
            end
            S_WR: begin
                w_next = ((r_cnt + 16'd1) == r_len) ? w_fin : S_DATA;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (in_valid) w_next = (in_data == r_xor) ? S_DONE : S_ERR;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_len   <= 16'd0;
            r_idx   <= 2'd0;
            r_wdata <= 32'd0;
            r_addr  <= BASE_ADDR;
            r_cnt   <= 16'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= 8'd0;
`endif
        end else begin
            r_state <= w_next;
            unique case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_addr <= BASE_ADDR;
                        r_cnt  <= 16'd0;
                        r_idx  <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor  <= 8'd0;
`endif
                    end
                end
                S_LEN0: begin
                    if (w_take) r_len[7:0] <= in_data;
                end
                S_LEN1: begin
                    if (w_take) r_len[15:8] <= in_data;
                end
                S_DATA: begin
                    if (w_take) begin
                        r_wdata[{r_idx, 3'b000} +: 8] <= in_data;
                        r_idx <= r_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor <= r_xor ^ in_data;
`endif
                    end
                end
                S_WR: begin
                    r_cnt  <= r_cnt + 16'd1;
                    r_addr <= r_addr + 32'd4;
                end
                default: ;
            endcase
        end
    end

endmodule
